// File: rtl/cc_pixel_packer.sv
// cc_pixel_packer: packs 16-bit camera pixels into 32-bit FIFO words per armed frame (CC_PACK_SWAP_EN swaps halves)
module cc_pixel_packer #(
  parameter int WORD_CNT_W = 24
) (
  input  logic                  cmos_clk_i,
  input  logic                  rst,
  input  logic [15:0]           cmos_data_i,
  input  logic                  cmos_valid_i,
  input  logic                  cmos_vsync_i,
  input  logic                  start,
  input  logic                  fifo_full_i,
  output logic [31:0]           data_out,
  output logic                  we,
  output logic                  busy,
  output logic                  frame_done,
  output logic [WORD_CNT_W-1:0] word_count,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
  state_t state, state_n;
  logic vs_q, pend_v, rise, fall, pair_now, flush_now, wr_req;
  logic [15:0] pend;
  logic [31:0] wr_word;
  assign rise = cmos_vsync_i & ~vs_q;
  assign fall = ~cmos_vsync_i & vs_q;
  assign pair_now = (state == CAPTURE) & cmos_valid_i & pend_v;
  assign flush_now = (state == FLUSH) & pend_v;
  assign wr_req = pair_now | flush_now;
`ifdef CC_PACK_SWAP_EN
  assign wr_word = flush_now ? {pend, 16'h0000} : {pend, cmos_data_i};
`else
  assign wr_word = flush_now ? {16'h0000, pend} : {cmos_data_i, pend};
`endif
  // state register
  always_ff @(posedge cmos_clk_i)
    state <= rst ? IDLE : state_n;
  // next-state: FLUSH always lasts exactly one cycle
  always_comb
    state_n = (state == IDLE && start)    ? ARMED   :
              (state == ARMED && rise)    ? CAPTURE :
              (state == CAPTURE && fall)  ? FLUSH   :
              (state == FLUSH)            ? IDLE    : state;
  // outputs decoded from state
  always_comb
    busy = (state == ARMED) || (state == CAPTURE);
  // datapath: vsync history, pending half-word, write strobe, counters
  always_ff @(posedge cmos_clk_i) begin
    if (rst) begin
      vs_q       <= 1'b0;
      pend_v     <= 1'b0;
      pend       <= '0;
      data_out   <= '0;
      we         <= 1'b0;
      frame_done <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      vs_q       <= cmos_vsync_i;
      we         <= wr_req & ~fifo_full_i;
      frame_done <= state == FLUSH;
      if (wr_req && !fifo_full_i) begin
        data_out <= wr_word;
        if (word_count != '1) word_count <= word_count + 1'b1;
      end
      if (wr_req && fifo_full_i) overflow <= 1'b1;
      if (state == IDLE && start) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (state == CAPTURE && cmos_valid_i) begin
        pend_v <= ~pend_v;
        if (!pend_v) pend <= cmos_data_i;
      end else if (state == FLUSH) pend_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cc_pixel_packer.sv
// tb_cc_pixel_packer: table-driven, directed and randomized checks of cc_pixel_packer
module tb_cc_pixel_packer;
  localparam int CW = 4;
  logic cmos_clk_i = 0, rst = 1, cmos_valid_i = 0, cmos_vsync_i = 0, start = 0, fifo_full_i = 0;
  logic [15:0] cmos_data_i = 0;
  logic [31:0] data_out;
  logic we, busy, frame_done, overflow;
  logic [CW-1:0] word_count;
  int n_cmp = 0, n_fail = 0, done_cnt = 0;
  logic [31:0] act_q[$], exp_q[$];
  logic [15:0] pix_q[$];
  bit merge;
  int full_at, exp_cnt;
  bit exp_ovf;

  cc_pixel_packer #(.WORD_CNT_W(CW)) dut (
    .cmos_clk_i(cmos_clk_i), .rst(rst), .cmos_data_i(cmos_data_i), .cmos_valid_i(cmos_valid_i),
    .cmos_vsync_i(cmos_vsync_i), .start(start), .fifo_full_i(fifo_full_i), .data_out(data_out),
    .we(we), .busy(busy), .frame_done(frame_done), .word_count(word_count), .overflow(overflow));

  always #5 cmos_clk_i = ~cmos_clk_i;

  always @(negedge cmos_clk_i) begin
    if (we) act_q.push_back(data_out);
    if (frame_done) done_cnt++;
  end

  typedef struct {
    int n; logic [15:0] px[4]; bit merge; int full_at;
    int nw; logic [31:0] w[2]; int cnt; bit ovf;
  } vec_t;
  vec_t vt[7];

  function automatic logic [31:0] sw(logic [31:0] w);
`ifdef CC_PACK_SWAP_EN
    return {w[15:0], w[31:16]};
`else
    return w;
`endif
  endfunction

  task automatic tick;
    @(posedge cmos_clk_i);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected stream: pixels paired in arrival order, odd tail flushed; a pair completed while full is lost
  task automatic model;
    int wr = 0;
    exp_q.delete();
    exp_ovf = 0;
    for (int i = 0; i < pix_q.size(); i += 2) begin
      logic [31:0] w = (i + 1 < pix_q.size()) ? {pix_q[i+1], pix_q[i]} : {16'h0000, pix_q[i]};
      if (full_at == i + 1) exp_ovf = 1;
      else begin
        exp_q.push_back(sw(w));
        wr++;
      end
    end
    exp_cnt = wr > (2**CW - 1) ? 2**CW - 1 : wr;
  endtask

  task automatic run_frame;
    act_q.delete();
    done_cnt = 0;
    start = 1; tick; start = 0;
    repeat (2) begin cmos_valid_i = 1; cmos_data_i = 16'($urandom); tick; end
    cmos_valid_i = 0;
    cmos_vsync_i = 1; tick;
    for (int i = 0; i < pix_q.size(); i++) begin
      repeat ($urandom_range(0, 2)) tick;
      cmos_data_i = pix_q[i];
      cmos_valid_i = 1;
      fifo_full_i = (i == full_at);
      if (merge && i == pix_q.size() - 1) cmos_vsync_i = 0;
      tick;
      cmos_valid_i = 0;
      if (i == full_at) begin tick; fifo_full_i = 0; end
    end
    if (cmos_vsync_i) begin cmos_vsync_i = 0; tick; end
    repeat (4) tick;
  endtask

  task automatic check_frame(string tag);
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) chk({tag, "_word"}, act_q[i], exp_q[i]);
    chk({tag, "_cnt"}, word_count, exp_cnt);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vt[0] = '{4, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 0, -1, 2, '{32'h22221111, 32'h44443333}, 2, 0};
    vt[1] = '{3, '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0}, 0, -1, 2, '{32'hBBBBAAAA, 32'h0000CCCC}, 2, 0};
    vt[2] = '{2, '{16'h1111, 16'h2222, 16'h0, 16'h0}, 0, -1, 1, '{32'h22221111, 32'h0}, 1, 0};
    vt[3] = '{1, '{16'h5555, 16'h0, 16'h0, 16'h0}, 0, -1, 1, '{32'h00005555, 32'h0}, 1, 0};
    vt[4] = '{0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, -1, 0, '{32'h0, 32'h0}, 0, 0};
    vt[5] = '{3, '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0}, 1, -1, 2, '{32'h0B0B0A0A, 32'h00000C0C}, 2, 0};
    vt[6] = '{4, '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 0, 3, 1, '{32'h22221111, 32'h0}, 1, 1};

    repeat (3) tick;
    chk("rst_data", data_out, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0; tick;

    foreach (vt[k]) begin
      pix_q.delete();
      for (int i = 0; i < vt[k].n; i++) pix_q.push_back(vt[k].px[i]);
      merge = vt[k].merge;
      full_at = vt[k].full_at;
      exp_q.delete();
      for (int i = 0; i < vt[k].nw; i++) exp_q.push_back(sw(vt[k].w[i]));
      exp_cnt = vt[k].cnt;
      exp_ovf = vt[k].ovf;
      run_frame;
      check_frame($sformatf("vec%0d", k));
    end
    start = 1; tick; start = 0;
    chk("rearm_ovf_clr", overflow, 0);
    chk("rearm_cnt_clr", word_count, 0);
    chk("rearm_busy", busy, 1);

    rst = 1; tick; rst = 0; tick;
    act_q.delete(); done_cnt = 0;
    cmos_vsync_i = 1; repeat (2) tick;
    start = 1; tick; start = 0;
    chk("midframe_busy", busy, 1);
    repeat (2) begin cmos_data_i = 16'h7777; cmos_valid_i = 1; tick; end
    cmos_valid_i = 0;
    cmos_vsync_i = 0; repeat (3) tick;
    chk("midframe_nwr", act_q.size(), 0);
    chk("midframe_nodone", done_cnt, 0);
    cmos_vsync_i = 1; tick;
    cmos_data_i = 16'h1234; cmos_valid_i = 1; tick;
    cmos_data_i = 16'h5678; tick;
    cmos_valid_i = 0; cmos_vsync_i = 0; repeat (4) tick;
    chk("midframe_after_nwr", act_q.size(), 1);
    if (act_q.size() > 0) chk("midframe_after_word", act_q[0], sw(32'h56781234));
    chk("midframe_after_done", done_cnt, 1);

    act_q.delete(); done_cnt = 0;
    start = 1; tick; start = 0;
    cmos_vsync_i = 1; tick;
    cmos_data_i = 16'h9999; cmos_valid_i = 1; tick;
    cmos_valid_i = 0; rst = 1; tick;
    chk("rstmid_data", data_out, 0);
    chk("rstmid_we", we, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", frame_done, 0);
    chk("rstmid_cnt", word_count, 0);
    chk("rstmid_ovf", overflow, 0);
    rst = 0; tick;
    cmos_vsync_i = 0; repeat (5) tick;
    chk("rstmid_nwr", act_q.size(), 0);
    chk("rstmid_nodone", done_cnt, 0);

    pix_q.delete();
    for (int i = 0; i < 40; i++) pix_q.push_back(16'(i * 16'h0101));
    merge = 0; full_at = -1;
    model; run_frame; check_frame("sat");

    for (int r = 0; r < 20; r++) begin
      int n = $urandom_range(0, 12);
      pix_q.delete();
      for (int i = 0; i < n; i++) pix_q.push_back(16'($urandom));
      merge = 1'($urandom);
      full_at = (n >= 2 && $urandom_range(0, 2) == 0) ? 2 * $urandom_range(0, n / 2 - 1) + 1 : -1;
      model; run_frame; check_frame($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
